// File: rtl/quad_decoder.sv
// Quadrature decoder: synchronizes asynchronous A/B phases, decodes gray-code
// transitions into step/direction/error pulses and keeps a wrapping position.
// Optional feature: define QUAD_DECODER_ERR_CNT_EN to add the saturating
// 8-bit err_cnt output.
module quad_decoder #(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             clr,
    input  logic             qa,
    input  logic             qb,
    output logic             step,
    output logic             up_down,
    output logic             hold,
    output logic             err,
    output logic [CNT_W-1:0] pos
`ifdef QUAD_DECODER_ERR_CNT_EN
    ,
    output logic [7:0]       err_cnt
`endif
);

    localparam int LAST = SYNC_STAGES - 1;

    typedef enum logic [1:0] {
        MOVE_NONE,
        MOVE_UP,
        MOVE_DOWN,
        MOVE_ILLEGAL
    } move_t;

    logic [SYNC_STAGES-1:0] sync_a;
    logic [SYNC_STAGES-1:0] sync_b;
    logic [1:0]             s;
    logic [1:0]             cur;
    logic [1:0]             prev;
    logic [2:0]             prime_cnt;
    logic [1:0]             diff;
    move_t                  move;

    // Position of a phase state along the up sequence 00->01->11->10.
    function automatic logic [1:0] gray_idx(input logic [1:0] st);
        case (st)
            2'b00:   gray_idx = 2'd0;
            2'b01:   gray_idx = 2'd1;
            2'b11:   gray_idx = 2'd2;
            default: gray_idx = 2'd3;
        endcase
    endfunction

    assign s = {sync_a[LAST], sync_b[LAST]};

    // Independent multi-flop synchronizers for each phase input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= {sync_a[SYNC_STAGES-2:0], qa};
            sync_b <= {sync_b[SYNC_STAGES-2:0], qb};
        end
    end

    // Classify the registered state against the previous one by gray distance.
    always_comb begin
        diff = gray_idx(cur) - gray_idx(prev);
        move = MOVE_NONE;
        case (diff)
            2'd1:    move = MOVE_UP;
            2'd3:    move = MOVE_DOWN;
            2'd2:    move = MOVE_ILLEGAL;
            default: move = MOVE_NONE;
        endcase
    end

    // Decode state, registered pulses and position counter.
    // The prime window spans the synchronizer fill plus the decode register,
    // so phases that are already non-zero at reset release seed prev/cur
    // directly instead of appearing as a transition out of the reset zeros.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur       <= 2'b00;
            prev      <= 2'b00;
            prime_cnt <= 3'(SYNC_STAGES + 1);
            step      <= 1'b0;
            up_down   <= 1'b0;
            hold      <= 1'b0;
            err       <= 1'b0;
            pos       <= '0;
`ifdef QUAD_DECODER_ERR_CNT_EN
            err_cnt   <= '0;
`endif
        end else begin
            step <= 1'b0;
            err  <= 1'b0;
            hold <= 1'b0;
            if (prime_cnt != 3'd0) begin
                prime_cnt <= prime_cnt - 3'd1;
                cur       <= s;
                prev      <= s;
                if (!ena || clr) begin
                    pos <= '0;
`ifdef QUAD_DECODER_ERR_CNT_EN
                    err_cnt <= '0;
`endif
                end
            end else begin
                cur  <= s;
                prev <= cur;
                if (!ena) begin
                    pos <= '0;
`ifdef QUAD_DECODER_ERR_CNT_EN
                    err_cnt <= '0;
`endif
                end else begin
                    case (move)
                        MOVE_UP: begin
                            step    <= 1'b1;
                            up_down <= 1'b1;
                            pos     <= pos + CNT_W'(1);
                        end
                        MOVE_DOWN: begin
                            step    <= 1'b1;
                            up_down <= 1'b0;
                            pos     <= pos - CNT_W'(1);
                        end
                        MOVE_ILLEGAL: begin
                            err <= 1'b1;
`ifdef QUAD_DECODER_ERR_CNT_EN
                            if (err_cnt != 8'hFF) begin
                                err_cnt <= err_cnt + 8'd1;
                            end
`endif
                        end
                        default: begin
                            hold <= 1'b1;
                        end
                    endcase
                    // Clear overrides the position update but not the pulses.
                    if (clr) begin
                        pos <= '0;
`ifdef QUAD_DECODER_ERR_CNT_EN
                        err_cnt <= '0;
`endif
                    end
                end
            end
        end
    end

endmodule
